video_pattern_gen: RTL

- Parametrised video timing and test-pattern source. Replaces the hand-coded 720x576@50 counter/pattern stimulus in the HDMI benches.
- Generates the pixel, blank, hsync and vsync streams for any progressive modeline. Four selectable patterns.
- Drives the hdmi encoder's I_R/I_G/I_B/I_BLANK/I_HSYNC/I_VSYNC directly. Synthesisable, so it also serves as an on-board HDMI bring-up source.

---
 rtl/video_pattern_pkg.sv | 42 ++++
 rtl/video_pattern_gen_timing.sv | 64 ++++++
 rtl/video_pattern_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_pkg.sv
// Shared definitions for the video timing / test-pattern source:
// pattern mode encoding, colour-bar palette and modeline total helper.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_t;

  // Bar colours as {R,G,B} "component on" flags.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen_timing.sv
// Raster counters for video_pattern_gen: hcnt/vcnt, active-area, hsync,
// vsync and start-of-frame decode, all relative to the current counter state.
module video_timing_counter
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 12,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 68,
  parameter int V_ACTIVE = 576,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 39,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          sof
);
  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic v_in_sync;
  logic vsync_hold;

  assign v_in_sync = (vcnt >= VS_START) && (vcnt < VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      vcnt       <= '0;
      vsync_hold <= 1'b0;
    end else begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
      end else begin
        hcnt <= hcnt + CW'(1);
      end
      if (hcnt == HS_START) vsync_hold <= v_in_sync;
    end
  end

  // vsync only re-evaluates on the hsync leading edge so both edges line up.
  assign vsync  = (hcnt == HS_START) ? v_in_sync : vsync_hold;
  assign hsync  = (hcnt >= HS_START) && (hcnt < HS_END);
  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign sof    = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern source for the HDMI encoder.
// Optional moving white bar overlay: define VIDEO_PATTERN_GEN_MOVING_BAR_EN.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 12,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 68,
  parameter int V_ACTIVE = 576,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 39,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int BPC      = 8,
  parameter int CW       = 12
) (
  input  logic             I_CLK_PIXEL,
  input  logic             I_RESET,
  input  logic [1:0]       I_MODE,
  input  logic [3*BPC-1:0] I_SOLID,
  output logic [BPC-1:0]   O_R,
  output logic [BPC-1:0]   O_G,
  output logic [BPC-1:0]   O_B,
  output logic             O_BLANK,
  output logic             O_HSYNC,
  output logic             O_VSYNC,
  output logic             O_SOF,
  output logic [CW-1:0]    O_X,
  output logic [CW-1:0]    O_Y
);
  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [CW-1:0]  X_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]  Y_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [BPC-1:0] PIX_MAX = {BPC{1'b1}};
  localparam logic [BPC-1:0] PIX_MID = BPC'(1 << (BPC - 1));
  localparam logic [BPC-1:0] PIX_ON  = BPC'(3 << (BPC - 2));

  generate
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_too_narrow
      $fatal(1, "video_pattern_gen: CW cannot hold H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  function automatic logic [2:0] bar_index(input logic [CW-1:0] x);
    int idx;
    idx = int'(x) / BAR_W;
    return (idx > 7) ? 3'd7 : idx[2:0];
  endfunction

  // ---- stage p0: counter state and combinational pattern ----
  logic [CW-1:0]    hcnt_p0, vcnt_p0;
  logic             active_p0, hsync_p0, vsync_p0, sof_p0;
  mode_t            mode_q, mode_p0;
  logic [3*BPC-1:0] solid_q, solid_p0;
  logic             border_p0;
  logic [2:0]       bar_rgb;
  logic [BPC-1:0]   r_p0, g_p0, b_p0;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_timing (
    .clk   (I_CLK_PIXEL),
    .rst   (I_RESET),
    .hcnt  (hcnt_p0),
    .vcnt  (vcnt_p0),
    .active(active_p0),
    .hsync (hsync_p0),
    .vsync (vsync_p0),
    .sof   (sof_p0)
  );

  // The frame's first pixel already uses the freshly sampled mode/colour.
  assign mode_p0  = sof_p0 ? mode_t'(I_MODE) : mode_q;
  assign solid_p0 = sof_p0 ? I_SOLID : solid_q;

  always_ff @(posedge I_CLK_PIXEL) begin
    if (I_RESET) begin
      mode_q <= MODE_BORDER;
    end else if (sof_p0) begin
      mode_q <= mode_t'(I_MODE);
    end
  end

  always_ff @(posedge I_CLK_PIXEL) begin
    if (sof_p0) solid_q <= I_SOLID;
  end

  assign border_p0 = (hcnt_p0 == '0) || (hcnt_p0 == X_LAST) ||
                     (vcnt_p0 == '0) || (vcnt_p0 == Y_LAST);

`ifdef VIDEO_PATTERN_GEN_MOVING_BAR_EN
  localparam logic [CW-1:0] BAR_X_LAST = CW'(H_ACTIVE - 8);
  localparam logic [CW-1:0] H_LAST_CNT = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_CNT = CW'(V_TOTAL - 1);

  logic [CW-1:0] bar_x;
  logic          in_bar_p0;

  // Advance on the edge that enters the SOF state so a whole frame shares one bar_x.
  always_ff @(posedge I_CLK_PIXEL) begin
    if (I_RESET) begin
      bar_x <= '0;
    end else if (hcnt_p0 == H_LAST_CNT && vcnt_p0 == V_LAST_CNT) begin
      bar_x <= (bar_x == BAR_X_LAST) ? '0 : bar_x + CW'(1);
    end
  end

  assign in_bar_p0 = (hcnt_p0 >= bar_x) && (hcnt_p0 < bar_x + CW'(8));
`endif

  always_comb begin
    r_p0    = '0;
    g_p0    = '0;
    b_p0    = '0;
    bar_rgb = bar_colour(bar_index(hcnt_p0));
    case (mode_p0)
      MODE_BORDER: begin
        if (border_p0) begin
          g_p0 = PIX_MAX;
        end else begin
          r_p0 = PIX_MID;
          g_p0 = PIX_MID;
          b_p0 = PIX_MID;
        end
      end
      MODE_BARS: begin
        r_p0 = bar_rgb[2] ? PIX_ON : '0;
        g_p0 = bar_rgb[1] ? PIX_ON : '0;
        b_p0 = bar_rgb[0] ? PIX_ON : '0;
      end
      MODE_CHECK: begin
        if (hcnt_p0[4] ^ vcnt_p0[4]) begin
          r_p0 = PIX_MAX;
          g_p0 = PIX_MAX;
          b_p0 = PIX_MAX;
        end
      end
      MODE_SOLID: {r_p0, g_p0, b_p0} = solid_p0;
      default: ;
    endcase
`ifdef VIDEO_PATTERN_GEN_MOVING_BAR_EN
    if (in_bar_p0 && !(mode_p0 == MODE_BORDER && border_p0)) begin
      r_p0 = PIX_MAX;
      g_p0 = PIX_MAX;
      b_p0 = PIX_MAX;
    end
`endif
    if (!active_p0) begin
      r_p0 = '0;
      g_p0 = '0;
      b_p0 = '0;
    end
  end

  // ---- stage p1: output registers ----
  logic [BPC-1:0] r_p1, g_p1, b_p1;
  logic           blank_p1, hsync_p1, vsync_p1, sof_p1;
  logic [CW-1:0]  x_p1, y_p1;

  always_ff @(posedge I_CLK_PIXEL) begin
    if (I_RESET) begin
      r_p1     <= '0;
      g_p1     <= '0;
      b_p1     <= '0;
      blank_p1 <= 1'b1;
      hsync_p1 <= ~H_POL;
      vsync_p1 <= ~V_POL;
      sof_p1   <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
    end else begin
      r_p1     <= r_p0;
      g_p1     <= g_p0;
      b_p1     <= b_p0;
      blank_p1 <= ~active_p0;
      hsync_p1 <= hsync_p0 ? H_POL : ~H_POL;
      vsync_p1 <= vsync_p0 ? V_POL : ~V_POL;
      sof_p1   <= sof_p0;
      x_p1     <= hcnt_p0;
      y_p1     <= vcnt_p0;
    end
  end

  assign O_R     = r_p1;
  assign O_G     = g_p1;
  assign O_B     = b_p1;
  assign O_BLANK = blank_p1;
  assign O_HSYNC = hsync_p1;
  assign O_VSYNC = vsync_p1;
  assign O_SOF   = sof_p1;
  assign O_X     = x_p1;
  assign O_Y     = y_p1;

endmodule
